// File: rtl/rv_pkg.sv
// Shared definitions for the RV64 decode-stage control: opcodes, ALUOp classes,
// ALU operation codes and the registered control bundle.
package rv_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [3:0] operation;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/rv_decode_ctrl_if.sv
// Decode-stage bus: instruction fields and pipeline controls in, ID/EX control half out.
// No valid/ready pair: en captures a new decode, flush captures a bubble, otherwise the stage holds.
interface rv_decode_ctrl_if;
    import rv_pkg::*;

    logic            en;
    logic            flush;
    logic [6:0]      opcode;
    logic [3:0]      funct;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;

    logic            branch;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic [1:0]      alu_op;
    logic [3:0]      operation;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_target;
    logic            illegal;

    modport master (
        output en, flush, opcode, funct, pc, imm,
        input  branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
        input  alu_op, operation, pc_plus4, branch_target, illegal
    );

    modport slave (
        input  en, flush, opcode, funct, pc, imm,
        output branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
        output alu_op, operation, pc_plus4, branch_target, illegal
    );

endinterface

// File: rtl/rv_add.sv
// Unsigned modulo-2^XLEN adder; the carry out is discarded.
module rv_add #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/rv_decode_ctrl.sv
// Decode-stage control: main control, ALU control and PC adders feeding a single
// ID/EX register stage (reset > flush > en > hold).
module rv_decode_ctrl
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    rv_decode_ctrl_if.slave bus
);

    ctrl_t           main_ctrl;
    logic [3:0]      alu_operation;
    logic [XLEN-1:0] imm_shl;
    logic [XLEN-1:0] pc_plus4_sum;
    logic [XLEN-1:0] branch_target_sum;

    ctrl_t           ctrl_d, ctrl_q;
    logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
    logic [XLEN-1:0] branch_target_d, branch_target_q;

    always_comb begin
        main_ctrl = '0;
        case (bus.opcode)
            OP_R: begin
                main_ctrl.reg_write = 1'b1;
                main_ctrl.alu_op    = ALUOP_R;
            end
            OP_I: begin
                main_ctrl.alu_src   = 1'b1;
                main_ctrl.reg_write = 1'b1;
                main_ctrl.alu_op    = ALUOP_I;
            end
            OP_LOAD: begin
                main_ctrl.mem_read   = 1'b1;
                main_ctrl.mem_to_reg = 1'b1;
                main_ctrl.alu_src    = 1'b1;
                main_ctrl.reg_write  = 1'b1;
                main_ctrl.alu_op     = ALUOP_MEM;
            end
            OP_STORE: begin
                main_ctrl.mem_write = 1'b1;
                main_ctrl.alu_src   = 1'b1;
                main_ctrl.alu_op    = ALUOP_MEM;
            end
            OP_BRANCH: begin
                main_ctrl.branch = 1'b1;
                main_ctrl.alu_op = ALUOP_BRANCH;
            end
            default: main_ctrl.illegal = 1'b1;
        endcase
    end

    // I-type ALU ops have no funct7 bit 30 except on shifts, where it picks srl/sra.
    always_comb begin
        alu_operation = ALU_ADD;
        case (main_ctrl.alu_op)
            ALUOP_MEM:    alu_operation = ALU_ADD;
            ALUOP_BRANCH: alu_operation = ALU_SUB;
            ALUOP_R: begin
                case (bus.funct)
                    4'b0000: alu_operation = ALU_ADD;
                    4'b1000: alu_operation = ALU_SUB;
                    4'b0111: alu_operation = ALU_AND;
                    4'b0110: alu_operation = ALU_OR;
                    4'b0100: alu_operation = ALU_XOR;
                    4'b0001: alu_operation = ALU_SLL;
                    4'b0101: alu_operation = ALU_SRL;
                    4'b1101: alu_operation = ALU_SRA;
                    default: alu_operation = ALU_ADD;
                endcase
            end
            ALUOP_I: begin
                case (bus.funct[2:0])
                    3'b000:  alu_operation = ALU_ADD;
                    3'b111:  alu_operation = ALU_AND;
                    3'b110:  alu_operation = ALU_OR;
                    3'b100:  alu_operation = ALU_XOR;
                    3'b001:  alu_operation = ALU_SLL;
                    3'b101:  alu_operation = bus.funct[3] ? ALU_SRA : ALU_SRL;
                    default: alu_operation = ALU_ADD;
                endcase
            end
            default: alu_operation = ALU_ADD;
        endcase
    end

    // Branch immediates are in halfword units; the shift drops imm's top bit.
    assign imm_shl = bus.imm << 1;

    rv_add #(.XLEN(XLEN)) u_pc_plus4 (
        .a   (bus.pc),
        .b   (PC_STEP),
        .sum (pc_plus4_sum)
    );

    rv_add #(.XLEN(XLEN)) u_branch_target (
        .a   (bus.pc),
        .b   (imm_shl),
        .sum (branch_target_sum)
    );

    always_comb begin
        ctrl_d          = ctrl_q;
        pc_plus4_d      = pc_plus4_q;
        branch_target_d = branch_target_q;
        if (bus.flush) begin
            ctrl_d          = '0;
            pc_plus4_d      = pc_plus4_sum;
            branch_target_d = branch_target_sum;
        end else if (bus.en) begin
            ctrl_d           = main_ctrl;
            ctrl_d.operation = alu_operation;
            pc_plus4_d       = pc_plus4_sum;
            branch_target_d  = branch_target_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q          <= '0;
            pc_plus4_q      <= '0;
            branch_target_q <= '0;
        end else begin
            ctrl_q          <= ctrl_d;
            pc_plus4_q      <= pc_plus4_d;
            branch_target_q <= branch_target_d;
        end
    end

    assign bus.branch        = ctrl_q.branch;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.alu_src       = ctrl_q.alu_src;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.operation     = ctrl_q.operation;
    assign bus.illegal       = ctrl_q.illegal;
    assign bus.pc_plus4      = pc_plus4_q;
    assign bus.branch_target = branch_target_q;

endmodule

// File: tb/tb_rv_decode_ctrl.sv
// Self-checking bench for rv_decode_ctrl: table of single-cycle decode vectors plus
// hand-written reset, stall and flush sequences.
module tb_rv_decode_ctrl;
    import rv_pkg::*;

    // Control field order: {branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,alu_op[1:0],operation[3:0],illegal}
    typedef struct {
        logic [6:0]  opcode;
        logic [3:0]  funct;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [12:0] exp_ctrl;
        logic [63:0] exp_pc4;
        logic [63:0] exp_bt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];

    rv_decode_ctrl_if bus ();

    rv_decode_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ctrl_now();
        return {bus.branch, bus.mem_read, bus.mem_to_reg, bus.mem_write, bus.alu_src,
                bus.reg_write, bus.alu_op, bus.operation, bus.illegal};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic en, input logic flush, input logic [6:0] opcode,
                         input logic [3:0] funct, input logic [63:0] pc, input logic [63:0] imm);
        bus.en     = en;
        bus.flush  = flush;
        bus.opcode = opcode;
        bus.funct  = funct;
        bus.pc     = pc;
        bus.imm    = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [6:0] opcode, input logic [3:0] funct, input logic [63:0] pc,
                           input logic [63:0] imm, input logic [12:0] ctrl,
                           input logic [63:0] pc4, input logic [63:0] bt);
        vec_t v;
        v.opcode = opcode; v.funct = funct; v.pc = pc; v.imm = imm;
        v.exp_ctrl = ctrl; v.exp_pc4 = pc4; v.exp_bt = bt;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic [12:0] ctrl,
                           input logic [63:0] pc4, input logic [63:0] bt);
        chk({tag, ".ctrl"}, 64'(ctrl_now()), 64'(ctrl));
        chk({tag, ".pc_plus4"}, bus.pc_plus4, pc4);
        chk({tag, ".branch_target"}, bus.branch_target, bt);
    endtask

    initial begin
        // R-type
        add_vec(7'b0110011, 4'b1000, 64'h100, 64'd8, 13'b000001_10_0110_0, 64'h104, 64'h110);
        add_vec(7'b0110011, 4'b0000, 64'h0, 64'h0, 13'b000001_10_0010_0, 64'h4, 64'h0);
        add_vec(7'b0110011, 4'b0111, 64'h10, 64'h1, 13'b000001_10_0000_0, 64'h14, 64'h12);
        add_vec(7'b0110011, 4'b0110, 64'h20, 64'h2, 13'b000001_10_0001_0, 64'h24, 64'h24);
        add_vec(7'b0110011, 4'b0100, 64'h30, 64'h3, 13'b000001_10_0011_0, 64'h34, 64'h36);
        add_vec(7'b0110011, 4'b0001, 64'h40, 64'h4, 13'b000001_10_0100_0, 64'h44, 64'h48);
        add_vec(7'b0110011, 4'b0101, 64'h50, 64'h5, 13'b000001_10_0101_0, 64'h54, 64'h5A);
        add_vec(7'b0110011, 4'b1101, 64'h60, 64'h6, 13'b000001_10_0111_0, 64'h64, 64'h6C);
        add_vec(7'b0110011, 4'b0010, 64'h70, 64'h0, 13'b000001_10_0010_0, 64'h74, 64'h70);
        add_vec(7'b0110011, 4'b1111, 64'h80, 64'h0, 13'b000001_10_0010_0, 64'h84, 64'h80);
        // I-type ALU: funct[3] only matters for the 101 shift
        add_vec(7'b0010011, 4'b1000, 64'h0, 64'h0, 13'b000011_11_0010_0, 64'h4, 64'h0);
        add_vec(7'b0010011, 4'b1111, 64'h0, 64'h0, 13'b000011_11_0000_0, 64'h4, 64'h0);
        add_vec(7'b0010011, 4'b1110, 64'h0, 64'h0, 13'b000011_11_0001_0, 64'h4, 64'h0);
        add_vec(7'b0010011, 4'b1100, 64'h0, 64'h0, 13'b000011_11_0011_0, 64'h4, 64'h0);
        add_vec(7'b0010011, 4'b1001, 64'h0, 64'h0, 13'b000011_11_0100_0, 64'h4, 64'h0);
        add_vec(7'b0010011, 4'b0101, 64'h0, 64'h0, 13'b000011_11_0101_0, 64'h4, 64'h0);
        add_vec(7'b0010011, 4'b1101, 64'h0, 64'h0, 13'b000011_11_0111_0, 64'h4, 64'h0);
        add_vec(7'b0010011, 4'b0010, 64'h0, 64'h0, 13'b000011_11_0010_0, 64'h4, 64'h0);
        // load, store, branch, wrap, illegal, imm MSB drop
        add_vec(7'b0000011, 4'b0011, 64'h1000, 64'h10, 13'b011011_00_0010_0, 64'h1004, 64'h1020);
        add_vec(7'b0100011, 4'b0011, 64'h2000, 64'h0, 13'b000110_00_0010_0, 64'h2004, 64'h2000);
        add_vec(7'b1100011, 4'b0000, 64'h200, 64'hFFFF_FFFF_FFFF_FFFC, 13'b100000_01_0110_0, 64'h204, 64'h1F8);
        add_vec(7'b0110011, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 13'b000001_10_0010_0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        add_vec(7'b1111111, 4'b0000, 64'h0, 64'h0, 13'b000000_00_0010_1, 64'h4, 64'h0);
        add_vec(7'b0110011, 4'b0000, 64'h0, 64'h8000_0000_0000_0001, 13'b000001_10_0010_0, 64'h4, 64'h2);
        add_vec(7'b0110011, 4'b0000, 64'h0, 64'h4000_0000_0000_0000, 13'b000001_10_0010_0, 64'h4, 64'h8000_0000_0000_0000);

        // Reset state
        reset = 1'b1;
        drive(1'b0, 1'b0, 7'b0, 4'b0, 64'h0, 64'h0);
        step();
        step();
        chk_all("reset", 13'b0, 64'h0, 64'h0);
        reset = 1'b0;

        // Table vectors, one decode per clock
        foreach (vecs[i]) begin
            drive(1'b1, 1'b0, vecs[i].opcode, vecs[i].funct, vecs[i].pc, vecs[i].imm);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].exp_ctrl, vecs[i].exp_pc4, vecs[i].exp_bt);
        end

        // Stall: capture a load, then en=0 with a store on the inputs must hold the load
        drive(1'b1, 1'b0, 7'b0000011, 4'b0, 64'h400, 64'h2);
        step();
        chk_all("stall_pre", 13'b011011_00_0010_0, 64'h404, 64'h404);
        drive(1'b0, 1'b0, 7'b0100011, 4'b0, 64'h500, 64'h8);
        step();
        step();
        chk_all("stall_hold", 13'b011011_00_0010_0, 64'h404, 64'h404);

        // Flush with en=0: bubble, but PC adders still load
        drive(1'b0, 1'b1, 7'b0110011, 4'b1000, 64'h300, 64'h4);
        step();
        chk_all("flush_en0", 13'b0, 64'h304, 64'h308);

        // Flush wins over en
        drive(1'b1, 1'b0, 7'b1100011, 4'b0, 64'h600, 64'h1);
        step();
        chk_all("pre_flush_en1", 13'b100000_01_0110_0, 64'h604, 64'h602);
        drive(1'b1, 1'b1, 7'b1100011, 4'b0, 64'h700, 64'h1);
        step();
        chk_all("flush_en1", 13'b0, 64'h704, 64'h702);

        // Mid-cycle async reset with nonzero outputs
        drive(1'b1, 1'b0, 7'b0000011, 4'b0, 64'h800, 64'h1);
        step();
        chk_all("pre_reset", 13'b011011_00_0010_0, 64'h804, 64'h802);
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 13'b0, 64'h0, 64'h0);
        #1 reset = 1'b0;
        drive(1'b1, 1'b0, 7'b0110011, 4'b0000, 64'h900, 64'h0);
        chk("no_capture_before_edge", 64'(bus.reg_write), 64'h0);
        step();
        chk("reg_write_after_reset", 64'(bus.reg_write), 64'h1);
        chk_all("after_reset", 13'b000001_10_0010_0, 64'h904, 64'h900);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
